// File: rtl/qeciphy_crc_stream.sv
// Frame-aware streaming CRC engine: 2-stage pipeline, byte-granular last beat, per-frame reinit.
// Optional receive-check mode (exp_crc_i, crc_err_o, err_cnt_o) under `QECIPHY_CRC_STREAM_CHECK_EN.
module qeciphy_crc_stream #(
    parameter int unsigned      DATA_W  = 64,
    parameter int unsigned      CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'('h1021),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'('hFFFF),
    parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'('h0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     tdata_i,
    input  logic [DATA_W/8-1:0]   tkeep_i,
    input  logic                  tlast_i,
    input  logic                  tvalid_i,
    output logic                  tready_o,
    output logic [CRC_W-1:0]      crc_o,
    output logic                  crc_valid_o,
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
    input  logic [CRC_W-1:0]      exp_crc_i,
    output logic                  crc_err_o,
    output logic [15:0]           err_cnt_o,
`endif
    input  logic                  crc_ready_i
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    // One byte through the non-reflected LFSR, MSB first.
    function automatic logic [CRC_W-1:0] byte_step(input logic [CRC_W-1:0] c_in,
                                                   input logic [7:0]       b);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ b[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    // Fold the first n bytes of a beat, byte 0 first.
    function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0]  c_in,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [CNT_W-1:0]  n);
        logic [CRC_W-1:0] c;
        c = c_in;
        for (int k = 0; k < int'(NB); k++) begin
            if (CNT_W'(k) < n) c = byte_step(c, d[8*k +: 8]);
        end
        return c;
    endfunction

    logic                s1_full_q, s1_full_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic [NB-1:0]       s1_keep_q, s1_keep_d;
    logic                s1_last_q, s1_last_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CRC_W-1:0]    res_q, res_d;
    logic                vld_q, vld_d;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0]    s1_exp_q, s1_exp_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
`endif

    logic                s1_adv_c;
    logic                tready_c;
    logic                accept_c;
    logic                run_c;
    logic [CNT_W-1:0]    nbytes_c;
    logic [CRC_W-1:0]    crc_next_c;

    // A pending result blocks only a last beat from overwriting it.
    always_comb begin
        s1_adv_c = s1_full_q && !(s1_last_q && vld_q && !crc_ready_i);
        tready_c = !rst_i && (!s1_full_q || s1_adv_c);
        accept_c = tvalid_i && tready_c;

        nbytes_c = CNT_W'(NB);
        run_c    = 1'b1;
        if (s1_last_q) begin
            nbytes_c = '0;
            for (int k = 0; k < int'(NB); k++) begin
                if (run_c && s1_keep_q[k]) nbytes_c = nbytes_c + CNT_W'(1);
                else                       run_c    = 1'b0;
            end
        end
        crc_next_c = crc_fold(crc_q, s1_data_q, nbytes_c);
    end

    always_comb begin
        s1_full_d = s1_full_q;
        s1_data_d = s1_data_q;
        s1_keep_d = s1_keep_q;
        s1_last_d = s1_last_q;
        crc_d     = crc_q;
        res_d     = res_q;
        vld_d     = vld_q;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
        s1_exp_d  = s1_exp_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        if (vld_q && crc_ready_i && err_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
`endif

        if (accept_c) begin
            s1_full_d = 1'b1;
            s1_data_d = tdata_i;
            s1_keep_d = tkeep_i;
            s1_last_d = tlast_i;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
            s1_exp_d  = exp_crc_i;
`endif
        end else if (s1_adv_c) begin
            s1_full_d = 1'b0;
        end

        if (vld_q && crc_ready_i) vld_d = 1'b0;

        // End of frame: publish the result and restart the state for the next frame.
        if (s1_adv_c) begin
            if (s1_last_q) begin
                res_d = crc_next_c ^ XOR_OUT;
                vld_d = 1'b1;
                crc_d = INIT;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
                err_d = ((crc_next_c ^ XOR_OUT) != s1_exp_q);
`endif
            end else begin
                crc_d = crc_next_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_full_q <= 1'b0;
            s1_data_q <= '0;
            s1_keep_q <= '0;
            s1_last_q <= 1'b0;
            crc_q     <= INIT;
            res_q     <= INIT ^ XOR_OUT;
            vld_q     <= 1'b0;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
            s1_exp_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            s1_full_q <= s1_full_d;
            s1_data_q <= s1_data_d;
            s1_keep_q <= s1_keep_d;
            s1_last_q <= s1_last_d;
            crc_q     <= crc_d;
            res_q     <= res_d;
            vld_q     <= vld_d;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
            s1_exp_q  <= s1_exp_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign tready_o    = tready_c;
    assign crc_o       = res_q;
    assign crc_valid_o = vld_q;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
    assign crc_err_o   = err_q;
    assign err_cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_qeciphy_crc_stream.sv
// Bench for qeciphy_crc_stream: randomized frames against a bitwise CRC reference model.
// Also covers a CRC-32/MPEG-2 instance and, when QECIPHY_CRC_STREAM_CHECK_EN is defined, check mode.
module tb_qeciphy_crc_stream;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid, tready;
    logic [15:0] crc;
    logic        crc_valid, crc_ready;

    logic [31:0] tdata32;
    logic [3:0]  tkeep32;
    logic        tlast32, tvalid32, tready32;
    logic [31:0] crc32;
    logic        crc_valid32, crc_ready32;

`ifdef QECIPHY_CRC_STREAM_CHECK_EN
    logic [15:0] exp_crc;
    logic        crc_err;
    logic [15:0] err_cnt;
    logic [31:0] exp_crc32;
    logic        crc_err32;
    logic [15:0] err_cnt32;
`endif

    int checks = 0;
    int errors = 0;
    bit saw_stall;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    qeciphy_crc_stream dut (
        .clk_i(clk), .rst_i(rst_i), .tdata_i(tdata), .tkeep_i(tkeep), .tlast_i(tlast),
        .tvalid_i(tvalid), .tready_o(tready), .crc_o(crc), .crc_valid_o(crc_valid),
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
        .exp_crc_i(exp_crc), .crc_err_o(crc_err), .err_cnt_o(err_cnt),
`endif
        .crc_ready_i(crc_ready)
    );

    qeciphy_crc_stream #(
        .DATA_W(32), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'h0)
    ) dut32 (
        .clk_i(clk), .rst_i(rst_i), .tdata_i(tdata32), .tkeep_i(tkeep32), .tlast_i(tlast32),
        .tvalid_i(tvalid32), .tready_o(tready32), .crc_o(crc32), .crc_valid_o(crc_valid32),
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
        .exp_crc_i(exp_crc32), .crc_err_o(crc_err32), .err_cnt_o(err_cnt32),
`endif
        .crc_ready_i(crc_ready32)
    );

    // Reference: textbook bit-serial CRC over a byte list.
    function automatic logic [31:0] model_crc(input logic [7:0] b[$], input int w,
                                              input logic [31:0] poly, input logic [31:0] init,
                                              input logic [31:0] xo);
        logic [63:0] c;
        logic        fb;
        c = 64'(init);
        foreach (b[i]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[w-1] ^ b[i][j];
                c  = (c << 1) & ((64'd1 << w) - 64'd1);
                if (fb) c = c ^ 64'(poly);
            end
        end
        return 32'(c) ^ xo;
    endfunction

    function automatic logic [15:0] model16(input logic [7:0] b[$]);
        return 16'(model_crc(b, 16, 32'h1021, 32'hFFFF, 32'h0));
    endfunction

    // Result monitor: records every completed handshake in order.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_i && crc_valid && crc_ready) got_q.push_back(crc);
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int g = 0;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
        #1;
        while (!tready && g < 1000) begin
            saw_stall = 1'b1;
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 1000) begin
            checks++; errors++;
            $display("FAIL beat_accept tready=%0b required 1 within 1000 cycles", tready);
        end
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        int n = q.size();
        logic [63:0] d;
        logic [7:0]  k;
        exp_q.push_back(model16(q));
        if (n == 0) begin
            send_beat({$urandom, $urandom}, 8'h00, 1'b1);
            return;
        end
        for (int i = 0; i < n; i += 8) begin
            d = {$urandom, $urandom};
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < n) begin
                    d[8*j +: 8] = q[i+j];
                    k[j] = 1'b1;
                end
            end
            send_beat(d, k, (i + 8 >= n));
        end
    endtask

    task automatic wait_got(input int n);
        int g = 0;
        while (got_q.size() < n && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
        end
    endtask

    task automatic wait_valid(output bit ok);
        int g = 0;
        while (!crc_valid && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        ok = crc_valid;
    endtask

    function automatic void make_digits(output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    endfunction

    function automatic void make_rand(input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready actual=%0b required=0", tready); end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0b required=0", crc_valid); end
        checks++;
        if (crc !== 16'hFFFF) begin errors++; $display("FAIL reset_crc actual=%h required=ffff", crc); end
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready_after actual=%0b required=1", tready); end
        checks++;
        if (crc32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_crc32 actual=%h required=ffffffff", crc32); end
    endtask

    task automatic test_known_vector();
        @(negedge clk);
        send_beat(64'h3837363534333231, 8'hFF, 1'b0);
        send_beat(64'hDEADBEEFCAFE0039, 8'h01, 1'b1);
        #1;
        checks++;
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL latency_early actual=%0b required=0", crc_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (crc_valid !== 1'b1) begin errors++; $display("FAIL latency_valid actual=%0b required=1", crc_valid); end
        checks++;
        if (crc !== 16'h29B1) begin errors++; $display("FAIL known_crc actual=%h required=29b1", crc); end
        repeat (2) @(negedge clk);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_keep();
        logic [7:0]  q[$];
        logic [7:0]  one[$];
        logic [63:0] d;
        logic [15:0] g, e;
        @(negedge clk);
        q = {};
        send_frame(q);
        exp_q[exp_q.size()-1] = 16'hFFFF;
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(8'h00);
        send_frame(q);
        make_rand(13, q);
        send_frame(q);
        d = {$urandom, $urandom};
        one = {d[7:0]};
        exp_q.push_back(model16(one));
        send_beat(d, 8'b1111_0101, 1'b1);
        wait_got(exp_q.size());
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL keep_count actual=%0d required=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL keep_crc actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[$];
        logic [15:0] g, e;
        @(negedge clk);
        crc_ready = 1'b0;
        saw_stall = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    make_rand(int'($urandom_range(1, 8)), q);
                    send_frame(q);
                end
            end
            begin
                repeat (5) @(negedge clk);
                crc_ready = 1'b1;
            end
        join
        checks++;
        if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall tready_dropped=%0b required=1", saw_stall); end
        wait_got(3);
        checks++;
        if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count actual=%0d required=3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_crc actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0]  q[$];
        logic [15:0] g, e;
        bit done = 1'b0;
        int n;
        @(negedge clk);
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    make_rand(int'($urandom_range(0, 40)), q);
                    send_frame(q);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000 && !done; c++) begin
                    @(negedge clk);
                    crc_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(negedge clk);
        crc_ready = 1'b1;
        n = exp_q.size();
        wait_got(n);
        checks++;
        if (got_q.size() !== n) begin errors++; $display("FAIL rand_count actual=%0d required=%0d", got_q.size(), n); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL rand_crc actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        bit ok;
        @(negedge clk);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid actual=%0b required=0", crc_valid); end
        @(negedge clk);
        crc_ready = 1'b0;
        make_rand(5, q);
        send_frame(q);
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_pend_setup valid=%0b required=1", crc_valid); end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL rst_pend_valid actual=%0b required=0", crc_valid); end
        crc_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL rst_pend_drop results=%0d required=0", got_q.size()); end
        got_q.delete(); exp_q.delete();
        @(negedge clk);
        make_digits(q);
        send_frame(q);
        wait_got(1);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 16'h29B1) begin
            errors++; $display("FAIL rst_after_crc actual=%h count=%0d required=29b1", got_q.size() > 0 ? got_q[0] : 16'h0, got_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_crc32();
        logic [7:0]  q[$];
        logic [31:0] m;
        int g = 0;
        make_digits(q);
        m = model_crc(q, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0);
        @(negedge clk);
        tdata32 = 32'h34333231; tkeep32 = 4'hF; tlast32 = 1'b0; tvalid32 = 1'b1;
        #1;
        checks++;
        if (tready32 !== 1'b1) begin errors++; $display("FAIL crc32_tready actual=%0b required=1", tready32); end
        @(negedge clk);
        tdata32 = 32'h38373635;
        @(negedge clk);
        tdata32 = 32'hAABBCC39; tkeep32 = 4'h1; tlast32 = 1'b1;
        @(negedge clk);
        tvalid32 = 1'b0; tlast32 = 1'b0;
        #1;
        while (!crc_valid32 && g < 50) begin @(negedge clk); #1; g++; end
        checks++;
        if (crc32 !== 32'h0376E6E7 || !crc_valid32) begin
            errors++; $display("FAIL crc32_known actual=%h valid=%0b required=0376e6e7", crc32, crc_valid32);
        end
        checks++;
        if (crc32 !== m) begin errors++; $display("FAIL crc32_model actual=%h required=%h", crc32, m); end
    endtask

`ifdef QECIPHY_CRC_STREAM_CHECK_EN
    task automatic test_check();
        logic [7:0] q[$];
        bit ok;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        crc_ready = 1'b0;
        make_digits(q);
        exp_crc = 16'h29B1;
        send_frame(q);
        wait_valid(ok);
        checks++;
        if (!ok || crc_err !== 1'b0) begin errors++; $display("FAIL chk_ok_err actual=%0b required=0", crc_err); end
        @(negedge clk);
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
        exp_crc = 16'h29B0;
        send_frame(q);
        wait_valid(ok);
        checks++;
        if (!ok || crc_err !== 1'b1) begin errors++; $display("FAIL chk_bad_err actual=%0b required=1", crc_err); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL chk_cnt_before actual=%0d required=0", err_cnt); end
        @(negedge clk);
        crc_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL chk_cnt actual=%0d required=1", err_cnt); end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0; crc_ready = 1'b1;
        tdata32 = '0; tkeep32 = '0; tlast32 = 1'b0; tvalid32 = 1'b0; crc_ready32 = 1'b1;
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
        exp_crc = '0; exp_crc32 = '0;
`endif
        test_reset();
        test_known_vector();
        test_keep();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_crc32();
`ifdef QECIPHY_CRC_STREAM_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
